// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment score scheduler.
// Optional build macro used by the design: OVERFLOW_SAT_EN.
package ssd_pkg;

  localparam logic [3:0] BCD_DASH = 4'hA;
  localparam int         MAX_DISP = 9999;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;
  typedef logic [3:0] bcd_t;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] add3_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Build macro: OVERFLOW_SAT_EN.
//   defined   : values above 9999 are clamped to 9999 and converted.
//   undefined : values above 9999 skip the shift phase and flag ovf_o.
// Handshake: start_i is honoured only in IDLE; done_o is high for the single
// DONE cycle, during which bcd_o and ovf_o hold the finished result.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [VAL_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [15:0]      bcd_o,
  output conv_state_t      state_o
);

  localparam int               CNT_W = $clog2(VAL_W + 1);
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_DISP);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(VAL_W - 1);

  conv_state_t      state_q, state_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      adj;
  logic             over;

  assign over = (value_i > MAX_V);

  // Next-state and datapath control for the conversion sequence.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    adj     = add3_adjust(bcd_q);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
`ifdef OVERFLOW_SAT_EN
          bin_d = over ? MAX_V : value_i;
          ovf_d = 1'b0;
`else
          bin_d = value_i;
          ovf_d = over;
`endif
        end
      end
      LOAD: begin
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = ovf_q ? DONE : SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign ovf_o   = ovf_q;
  assign bcd_o   = bcd_q;
  assign state_o = state_q;

endmodule

// File: rtl/ssd_score_sched.sv
// Seven-segment display scheduler: arbitrates live score (A) and high score
// (B), alternates between them on a dwell timer, and converts the chosen
// value to four stable BCD digits.
// Build macro: OVERFLOW_SAT_EN (values above 9999 show 9999 instead of dashes).
// Handshake: a transfer on source x happens on any edge where x_valid and
// x_ready are both high; x_ready drops only while source x is being converted.
module ssd_score_sched
  import ssd_pkg::*;
#(
  parameter int VAL_W        = 14,
  parameter int DWELL_CYCLES = 200_000_000,
  parameter int DWELL_W      = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [VAL_W-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [VAL_W-1:0] b_data,
  output logic             b_ready,
  input  logic             alt_en,
  input  logic             src_sel,
  output bcd_t             dig0,
  output bcd_t             dig1,
  output bcd_t             dig2,
  output bcd_t             dig3,
  output logic             cur_src,
  output logic             busy,
  output logic             upd,
  output conv_state_t      dbg_state
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  logic [VAL_W-1:0]   val_a_q, val_b_q;
  logic               dirty_a_q, dirty_a_d;
  logic               dirty_b_q, dirty_b_d;
  logic               cur_src_q, cur_src_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               alt_phase_q, alt_phase_d;
  bcd_t               dig0_q, dig1_q, dig2_q, dig3_q;
  logic               upd_q;

  logic               tgt, dirty_tgt, start;
  logic [VAL_W-1:0]   val_tgt;
  logic               conv_busy, conv_done, conv_ovf;
  logic [15:0]        conv_bcd;
  conv_state_t        conv_state;
  logic               acc_a, acc_b;

  assign tgt       = alt_en ? alt_phase_q : src_sel;
  assign dirty_tgt = tgt ? dirty_b_q : dirty_a_q;
  assign val_tgt   = tgt ? val_b_q : val_a_q;
  assign start     = (conv_state == IDLE) && ((tgt != cur_src_q) || dirty_tgt);

  assign a_ready = !(conv_busy && !cur_src_q);
  assign b_ready = !(conv_busy && cur_src_q);
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;

  bin2bcd_seq #(
    .VAL_W (VAL_W)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .value_i (val_tgt),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .ovf_o   (conv_ovf),
    .bcd_o   (conv_bcd),
    .state_o (conv_state)
  );

  // Dirty flags and source selection; a new transfer wins over the clear.
  always_comb begin
    dirty_a_d = dirty_a_q;
    dirty_b_d = dirty_b_q;
    cur_src_d = cur_src_q;
    if (start) begin
      cur_src_d = tgt;
      if (tgt) dirty_b_d = 1'b0;
      else     dirty_a_d = 1'b0;
    end
    if (acc_a) dirty_a_d = 1'b1;
    if (acc_b) dirty_b_d = 1'b1;
  end

  // Dwell timer: counts only in alternate mode, flips the phase on wrap.
  always_comb begin
    dwell_d     = dwell_q;
    alt_phase_d = alt_phase_q;
    if (alt_en) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d     = '0;
        alt_phase_d = !alt_phase_q;
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end else begin
      dwell_d = '0;
    end
  end

  // Requester values, flags, selection and dwell registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_a_q     <= '0;
      val_b_q     <= '0;
      dirty_a_q   <= 1'b1;
      dirty_b_q   <= 1'b1;
      cur_src_q   <= 1'b0;
      dwell_q     <= '0;
      alt_phase_q <= 1'b0;
    end else begin
      if (acc_a) val_a_q <= a_data;
      if (acc_b) val_b_q <= b_data;
      dirty_a_q   <= dirty_a_d;
      dirty_b_q   <= dirty_b_d;
      cur_src_q   <= cur_src_d;
      dwell_q     <= dwell_d;
      alt_phase_q <= alt_phase_d;
    end
  end

  // Digit outputs only load from a finished conversion; upd marks the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig0_q <= '0;
      dig1_q <= '0;
      dig2_q <= '0;
      dig3_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      upd_q <= conv_done;
      if (conv_done) begin
        if (conv_ovf) begin
          dig0_q <= BCD_DASH;
          dig1_q <= BCD_DASH;
          dig2_q <= BCD_DASH;
          dig3_q <= BCD_DASH;
        end else begin
          dig0_q <= conv_bcd[3:0];
          dig1_q <= conv_bcd[7:4];
          dig2_q <= conv_bcd[11:8];
          dig3_q <= conv_bcd[15:12];
        end
      end
    end
  end

  assign dig0      = dig0_q;
  assign dig1      = dig1_q;
  assign dig2      = dig2_q;
  assign dig3      = dig3_q;
  assign cur_src   = cur_src_q;
  assign busy      = conv_busy;
  assign upd       = upd_q;
  assign dbg_state = conv_state;

endmodule

// File: doc/ssd_score_sched.md
Name: ssd_score_sched

Overview:
- Sequences the 4-digit seven-segment driver for the snake game.
- Two requesters share the display: live score (A) and high score (B). Each pushes a binary value through a valid/ready handshake.
- The block picks which source is shown, either fixed or alternating on a dwell timer.
- It converts the chosen binary value to four BCD digits with a sequential shift-add-3 (double-dabble) engine, then holds digit outputs stable for the driver's in0..in3.

Parameters:
- VAL_W, 14, binary width of requester values (must hold 0..9999).
- DWELL_CYCLES, 200_000_000, clk cycles each source stays displayed in alternate mode (2 s at 100 MHz).
- DWELL_W, 28, dwell counter width; must satisfy 2^DWELL_W > DWELL_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  score requester has a new value
- a_data  in  VAL_W  score value
- a_ready  out  1  score value accepted when a_valid && a_ready
- b_valid  in  1  high-score requester has a new value
- b_data  in  VAL_W  high-score value
- b_ready  out  1  high-score value accepted when b_valid && b_ready
- alt_en  in  1  1 = alternate A/B every DWELL_CYCLES; 0 = show src_sel only
- src_sel  in  1  fixed source when alt_en=0 (0=A, 1=B)
- dig0, dig1, dig2, dig3  out  4 each  BCD digits, ones..thousands; codes 0-9, 4'hA = dash
- cur_src  out  1  source currently shown
- busy  out  1  conversion in progress
- upd  out  1  one-cycle pulse when digits change

Behaviour:
- Reset (async assert, sync release):
  - val_a = val_b = 0; dirty_a = dirty_b = 1.
  - cur_src = 0, dwell counter = 0, state = IDLE.
  - dig0..dig3 = 0, busy = 0, upd = 0.
  - a_ready = b_ready = 1.
- Requester storage:
  - x_ready = 0 only while state != IDLE and the conversion is converting source x; otherwise 1.
  - An accepted transfer writes val_x and sets dirty_x on the same edge.
  - A and B may both be accepted in the same cycle.
- Target source: tgt = alt_en ? alt_phase : src_sel.
  - alt_phase toggles when the dwell counter reaches DWELL_CYCLES-1; the counter then wraps to 0.
  - The dwell counter runs only while alt_en=1 and holds at 0 while alt_en=0.
- FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE:
  - IDLE: if tgt != cur_src or dirty_tgt, go to LOAD. Set cur_src = tgt, clear dirty_tgt, latch val_tgt into the shift register. busy = 1 from LOAD onward.
  - A dirty flag set in the same cycle it is cleared stays set, so a re-conversion follows.
  - LOAD: clear the BCD accumulator; iteration counter = 0.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. Runs exactly VAL_W cycles.
  - DONE: write the four nibbles to dig0..dig3, pulse upd for one cycle, busy = 0, return to IDLE.
- Latency: VAL_W + 3 cycles from trigger to upd (17 at default).
- Digit outputs change only in DONE; they never show a partially converted value.
- Overrange (value > 9999): see the optional feature.
- tgt changing mid-conversion: the current conversion finishes, then IDLE re-evaluates. No abort.
- Reset mid-conversion: immediate return to reset values.
- cur_src changes at the LOAD edge, not at DONE. The bench samples cur_src together with upd.

Optional Feature:
- Macro OVERFLOW_SAT_EN.
- Defined: a value > 9999 is saturated to 9999 before conversion, displaying 9999.
- Undefined: a value > 9999 skips SHIFT. DONE drives all four digits to 4'hA (dashes) and still pulses upd. Latency is 3 cycles.

Decomposition:
- Package ssd_pkg:
  - BCD_DASH = 4'hA, MAX_DISP = 9999.
  - typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t.
  - typedef logic [3:0] bcd_t.
- Sub-module bin2bcd_seq (start/done, shift-add-3 engine).
- Arbitration, dwell timer and handshake logic stay in ssd_score_sched.

Test Plan:
- Reset, then idle with alt_en=0 and src_sel=0 -> a conversion of val_a=0 runs; upd at cycle 17; digits 0,0,0,0; cur_src=0.
- a_valid with a_data=1234 -> dig3..dig0 = 1,2,3,4 with one upd pulse 17 cycles after the trigger. a_ready is low during that conversion.
- A=42 and B=9876 accepted in the same cycle; src_sel switched 0->1 mid-conversion of A -> first upd shows 0042, then a second conversion shows 9876 with cur_src=1.
- alt_en=1, DWELL_CYCLES overridden to 50, A=7, B=300 -> display alternates 0007/0300 every 50 cycles, with one upd per switch.
- a_data=12000 -> with OVERFLOW_SAT_EN: 9999. Without the macro: four 4'hA, upd 3 cycles after the trigger.
- rst_n asserted during SHIFT -> outputs are immediately 0, busy=0; the next conversion after release completes normally.
